// File: rtl/scaler_cfg_ctrl_if.sv
// rtl/scaler_cfg_ctrl_if.sv - CPU-side config request/response bundle for scaler_cfg_ctrl
interface scaler_cfg_ctrl_if #(
  parameter int X_W = 11,
  parameter int Y_W = 11
);
  logic           cfg_wr;
  logic [X_W:0]   cfg_start_x;
  logic [X_W:0]   cfg_end_x;
  logic [Y_W:0]   cfg_start_y;
  logic [Y_W:0]   cfg_end_y;
  logic [X_W-1:0] cfg_out_xres;
  logic [Y_W-1:0] cfg_out_yres;
  logic           cfg_ack;
  logic           cfg_err;
  logic           cfg_busy;
  logic           cfg_pending;

  modport master (
    output cfg_wr, cfg_start_x, cfg_end_x, cfg_start_y, cfg_end_y, cfg_out_xres, cfg_out_yres,
    input  cfg_ack, cfg_err, cfg_busy, cfg_pending
  );

  modport slave (
    input  cfg_wr, cfg_start_x, cfg_end_x, cfg_start_y, cfg_end_y, cfg_out_xres, cfg_out_yres,
    output cfg_ack, cfg_err, cfg_busy, cfg_pending
  );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// rtl/scaler_cfg_ctrl.sv - vsync-atomic crop/scale config controller with shared Q4.14 divider
// Define SCALER_CFG_ROUND_EN for round-to-nearest scale factors (truncating otherwise).
module scaler_cfg_ctrl #(
  parameter int X_W             = 11,
  parameter int Y_W             = 11,
  parameter int H_DISP          = 1280,
  parameter int V_DISP          = 720,
  parameter int SCALE_INT_BITS  = 4,
  parameter int SCALE_FRAC_BITS = 14,
  parameter int SB              = SCALE_INT_BITS + SCALE_FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  scaler_cfg_ctrl_if.slave        cfg,
  input  logic                    vs_i,
  output logic [X_W:0]            start_x,
  output logic [X_W:0]            end_x,
  output logic [Y_W:0]            start_y,
  output logic [Y_W:0]            end_y,
  output logic [X_W-1:0]          input_x_res,
  output logic [Y_W-1:0]          input_y_res,
  output logic [X_W-1:0]          output_x_res,
  output logic [Y_W-1:0]          output_y_res,
  output logic [SB-1:0]           x_scale,
  output logic [SB-1:0]           y_scale,
  output logic                    scaler_start,
  output logic                    cfg_applied
);
  localparam int DW   = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam int NW   = DW + SCALE_FRAC_BITS;
  localparam int ITER = NW - 1;
  localparam int CW   = $clog2(ITER);

  localparam logic [X_W:0]    X_SPAN = {1'b1, {X_W{1'b0}}};
  localparam logic [Y_W:0]    Y_SPAN = {1'b1, {Y_W{1'b0}}};
  localparam logic [X_W:0]    X_LIM  = (X_W+1)'(H_DISP);
  localparam logic [Y_W:0]    Y_LIM  = (Y_W+1)'(V_DISP);
  localparam logic [SB-1:0]   UNITY  = SB'(1) << SCALE_FRAC_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_DIV_X, ST_DIV_Y, ST_PEND} state_t;

  state_t          state_q;
  logic            vs_q;
  logic            ack_q, err_q, busy_q, pending_q, start_q, applied_q;

  logic [X_W:0]    start_x_q, end_x_q, sh_sx_q, sh_ex_q;
  logic [Y_W:0]    start_y_q, end_y_q, sh_sy_q, sh_ey_q;
  logic [X_W-1:0]  in_xr_q, out_xr_q, sh_ox_q;
  logic [Y_W-1:0]  in_yr_q, out_yr_q, sh_oy_q;
  logic [SB-1:0]   x_scale_q, y_scale_q, sh_xs_q;

  logic [DW-1:0]   rem_q, dvs_q;
  logic [NW-2:0]   num_q;
  logic [SB-1:0]   quo_q;
  logic            sat_q;
  logic [CW-1:0]   cnt_q;

  logic            vs_rise;
  logic [X_W:0]    dx_in;
  logic [Y_W:0]    dy_in;
  logic            x_bad, y_bad, req_ok;
  logic [DW-1:0]   ld_diff, ld_dvs;
  logic [NW-1:0]   ld_num;
  logic            ld_ovf;
  logic [DW:0]     rsh;
  logic            qbit, sat_d, last_d;
  logic [DW-1:0]   rem_d;
  logic [SB-1:0]   quo_d, scale_d;

  assign vs_rise = vs_i & ~vs_q;

  always_comb begin
    dx_in  = cfg.cfg_end_x - cfg.cfg_start_x;
    dy_in  = cfg.cfg_end_y - cfg.cfg_start_y;
    x_bad  = (cfg.cfg_end_x <= cfg.cfg_start_x) || (dx_in > X_SPAN) || (cfg.cfg_end_x > X_LIM);
    y_bad  = (cfg.cfg_end_y <= cfg.cfg_start_y) || (dy_in > Y_SPAN) || (cfg.cfg_end_y > Y_LIM);
    req_ok = !x_bad && !y_bad;
  end

  // Divider operand loader: X comes straight from the request, Y from the shadow set.
  always_comb begin
    if (state_q == ST_DIV_X) begin
      ld_diff = DW'(sh_ey_q - sh_sy_q);
      ld_dvs  = DW'(sh_oy_q) + DW'(1);
    end else begin
      ld_diff = DW'(dx_in);
      ld_dvs  = DW'(cfg.cfg_out_xres) + DW'(1);
    end
    ld_num = NW'(ld_diff) << SCALE_FRAC_BITS;
`ifdef SCALER_CFG_ROUND_EN
    ld_num = ld_num + NW'(ld_dvs >> 1);
`endif
    // The numerator MSB is resolved at load so each axis needs only NW-1 iterations.
    ld_ovf = ld_num[NW-1] && (ld_dvs == DW'(1));
  end

  always_comb begin
    rsh     = {rem_q, num_q[NW-2]};
    qbit    = rsh >= {1'b0, dvs_q};
    rem_d   = qbit ? (rsh[DW-1:0] - dvs_q) : rsh[DW-1:0];
    quo_d   = {quo_q[SB-2:0], qbit};
    sat_d   = sat_q | quo_q[SB-1];
    scale_d = sat_d ? {SB{1'b1}} : quo_d;
    last_d  = (cnt_q == CW'(ITER-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vs_q      <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      applied_q <= 1'b0;
      start_x_q <= '0;
      end_x_q   <= X_LIM;
      start_y_q <= '0;
      end_y_q   <= Y_LIM;
      in_xr_q   <= X_W'(H_DISP - 1);
      in_yr_q   <= Y_W'(V_DISP - 1);
      out_xr_q  <= X_W'(H_DISP - 1);
      out_yr_q  <= Y_W'(V_DISP - 1);
      x_scale_q <= UNITY;
      y_scale_q <= UNITY;
      sh_sx_q   <= '0;
      sh_ex_q   <= '0;
      sh_sy_q   <= '0;
      sh_ey_q   <= '0;
      sh_ox_q   <= '0;
      sh_oy_q   <= '0;
      sh_xs_q   <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      vs_q      <= vs_i;
      start_q   <= vs_rise;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      applied_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_PEND: begin
          if (state_q == ST_PEND && vs_rise) begin
            start_x_q <= sh_sx_q;
            end_x_q   <= sh_ex_q;
            start_y_q <= sh_sy_q;
            end_y_q   <= sh_ey_q;
            in_xr_q   <= X_W'(sh_ex_q - sh_sx_q - 1'b1);
            in_yr_q   <= Y_W'(sh_ey_q - sh_sy_q - 1'b1);
            out_xr_q  <= sh_ox_q;
            out_yr_q  <= sh_oy_q;
            x_scale_q <= sh_xs_q;
            y_scale_q <= quo_q;
            applied_q <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (cfg.cfg_wr) begin
            if (req_ok) begin
              sh_sx_q   <= cfg.cfg_start_x;
              sh_ex_q   <= cfg.cfg_end_x;
              sh_sy_q   <= cfg.cfg_start_y;
              sh_ey_q   <= cfg.cfg_end_y;
              sh_ox_q   <= cfg.cfg_out_xres;
              sh_oy_q   <= cfg.cfg_out_yres;
              rem_q     <= ld_ovf ? '0 : DW'(ld_num[NW-1]);
              sat_q     <= ld_ovf;
              num_q     <= ld_num[NW-2:0];
              dvs_q     <= ld_dvs;
              quo_q     <= '0;
              cnt_q     <= '0;
              ack_q     <= 1'b1;
              busy_q    <= 1'b1;
              pending_q <= 1'b0;
              state_q   <= ST_DIV_X;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DIV_X, ST_DIV_Y: begin
          rem_q <= rem_d;
          num_q <= num_q << 1;
          quo_q <= quo_d;
          sat_q <= sat_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_d) begin
            err_q <= sat_d;
            if (state_q == ST_DIV_X) begin
              sh_xs_q <= scale_d;
              rem_q   <= ld_ovf ? '0 : DW'(ld_num[NW-1]);
              sat_q   <= ld_ovf;
              num_q   <= ld_num[NW-2:0];
              dvs_q   <= ld_dvs;
              quo_q   <= '0;
              cnt_q   <= '0;
              state_q <= ST_DIV_Y;
            end else begin
              // quo_q doubles as the pending Y scale until commit.
              quo_q     <= scale_d;
              busy_q    <= 1'b0;
              pending_q <= 1'b1;
              state_q   <= ST_PEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg.cfg_ack     = ack_q;
  assign cfg.cfg_err     = err_q;
  assign cfg.cfg_busy    = busy_q;
  assign cfg.cfg_pending = pending_q;
  assign start_x         = start_x_q;
  assign end_x           = end_x_q;
  assign start_y         = start_y_q;
  assign end_y           = end_y_q;
  assign input_x_res     = in_xr_q;
  assign input_y_res     = in_yr_q;
  assign output_x_res    = out_xr_q;
  assign output_y_res    = out_yr_q;
  assign x_scale         = x_scale_q;
  assign y_scale         = y_scale_q;
  assign scaler_start    = start_q;
  assign cfg_applied     = applied_q;
endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// tb/tb_scaler_cfg_ctrl.sv - self-checking bench for scaler_cfg_ctrl (honours SCALER_CFG_ROUND_EN)
module tb_scaler_cfg_ctrl;
  typedef struct {
    logic [11:0] sx, ex, sy, ey;
    logic [10:0] ox, oy;
    bit          acc;
    logic [17:0] xs, ys;
    int          nerr;
  } vec_t;

`ifdef SCALER_CFG_ROUND_EN
  localparam int R3 = 'h2AAB;
  localparam int R5 = 'h599A;
`else
  localparam int R3 = 'h2AAA;
  localparam int R5 = 'h5999;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_i = 1'b0;
  logic [11:0] start_x, end_x, start_y, end_y;
  logic [10:0] input_x_res, input_y_res, output_x_res, output_y_res;
  logic [17:0] x_scale, y_scale;
  logic        scaler_start, cfg_applied;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t exp_q[$];
  vec_t cur;
  vec_t mon_e;
  bit   model_pend = 1'b0;
  vec_t vecs[11];

  scaler_cfg_ctrl_if ifc ();

  scaler_cfg_ctrl dut (
    .clk(clk), .rst(rst), .cfg(ifc), .vs_i(vs_i),
    .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
    .input_x_res(input_x_res), .input_y_res(input_y_res),
    .output_x_res(output_x_res), .output_y_res(output_y_res),
    .x_scale(x_scale), .y_scale(y_scale),
    .scaler_start(scaler_start), .cfg_applied(cfg_applied)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int sx, int ex, int sy, int ey, int ox, int oy,
                              bit acc, int xs, int ys, int nerr);
    vec_t v;
    v.sx = 12'(sx); v.ex = 12'(ex); v.sy = 12'(sy); v.ey = 12'(ey);
    v.ox = 11'(ox); v.oy = 11'(oy); v.acc = acc;
    v.xs = 18'(xs); v.ys = 18'(ys); v.nerr = nerr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_start_x"}, start_x, 0);
    chk({tag, "_end_x"}, end_x, 1280);
    chk({tag, "_end_y"}, end_y, 720);
    chk({tag, "_in_xres"}, input_x_res, 1279);
    chk({tag, "_in_yres"}, input_y_res, 719);
    chk({tag, "_out_yres"}, output_y_res, 719);
    chk({tag, "_x_scale"}, x_scale, 'h4000);
    chk({tag, "_y_scale"}, y_scale, 'h4000);
    chk({tag, "_busy"}, ifc.cfg_busy, 0);
    chk({tag, "_pending"}, ifc.cfg_pending, 0);
    chk({tag, "_applied"}, cfg_applied, 0);
    chk({tag, "_sstart"}, scaler_start, 0);
  endtask

  task automatic drive(input vec_t v);
    ifc.cfg_start_x = v.sx; ifc.cfg_end_x = v.ex;
    ifc.cfg_start_y = v.sy; ifc.cfg_end_y = v.ey;
    ifc.cfg_out_xres = v.ox; ifc.cfg_out_yres = v.oy;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    ifc.cfg_wr = 1'b1;
    tick();
    ifc.cfg_wr = 1'b0;
    chk("ack", ifc.cfg_ack, 32'(v.acc));
    chk("reject_err", ifc.cfg_err, 32'(!v.acc));
    if (v.acc) begin
      chk("busy_after_ack", ifc.cfg_busy, 1);
      if (model_pend) void'(exp_q.pop_back());
      model_pend = 1'b0;
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_pend(input int n0, input int exp_cycles, input int exp_err);
    int n;
    int errs;
    n = n0;
    errs = 0;
    while (!ifc.cfg_pending && n < 200) begin
      tick();
      n++;
      if (ifc.cfg_err) errs++;
    end
    chk("pend_latency", n, exp_cycles);
    chk("sat_err_count", errs, exp_err);
    chk("busy_in_pend", ifc.cfg_busy, 0);
    model_pend = 1'b1;
  endtask

  task automatic vsync_pulse(input bit commit);
    vs_i = 1'b1;
    tick();
    chk("sstart_on_edge", scaler_start, 1);
    chk("applied_on_edge", cfg_applied, 32'(commit));
    if (!commit) chk("xscale_kept", x_scale, cur.xs);
    tick();
    chk("sstart_one_cycle", scaler_start, 0);
    chk("applied_one_cycle", cfg_applied, 0);
    vs_i = 1'b0;
    tick();
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && cfg_applied) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_apply actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_start_x", start_x, mon_e.sx);
        chk("sb_end_x", end_x, mon_e.ex);
        chk("sb_start_y", start_y, mon_e.sy);
        chk("sb_end_y", end_y, mon_e.ey);
        chk("sb_in_xres", input_x_res, 11'(mon_e.ex - mon_e.sx - 12'd1));
        chk("sb_in_yres", input_y_res, 11'(mon_e.ey - mon_e.sy - 12'd1));
        chk("sb_out_xres", output_x_res, mon_e.ox);
        chk("sb_out_yres", output_y_res, mon_e.oy);
        chk("sb_x_scale", x_scale, mon_e.xs);
        chk("sb_y_scale", y_scale, mon_e.ys);
        chk("sb_sstart_with_apply", scaler_start, 1);
        cur = mon_e;
        model_pend = 1'b0;
      end
    end
  end

  initial begin
    vecs[0]  = mk(0, 640, 0, 360, 1279, 719, 1, 'h2000, 'h2000, 0);
    vecs[1]  = mk(0, 2, 0, 2, 2, 2, 1, R3, R3, 0);
    vecs[2]  = mk(0, 100, 0, 4, 2, 3, 1, 'h3FFFF, 'h4000, 1);
    vecs[3]  = mk(10, 10, 0, 720, 100, 100, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1281, 0, 720, 100, 100, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1280, 0, 721, 100, 100, 0, 0, 0, 0);
    vecs[6]  = mk(500, 400, 0, 10, 100, 100, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1280, 0, 720, 639, 359, 1, 'h8000, 'h8000, 0);
    vecs[8]  = mk(256, 1280, 0, 720, 0, 1439, 1, 'h3FFFF, 'h2000, 1);
    vecs[9]  = mk(3, 10, 5, 6, 4, 0, 1, R5, 'h4000, 0);
    vecs[10] = mk(0, 10, 0, 700, 100, 0, 1, 'h656, 'h3FFFF, 1);
    cur = mk(0, 1280, 0, 720, 1279, 719, 1, 'h4000, 'h4000, 0);

    ifc.cfg_wr = 1'b0;
    drive(vecs[3]);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_defaults("reset");
    chk("reset_ack", ifc.cfg_ack, 0);
    chk("reset_err", ifc.cfg_err, 0);
    vsync_pulse(1'b0);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i]);
      if (vecs[i].acc) begin
        wait_pend(1, 51, vecs[i].nerr);
        vsync_pulse(1'b1);
      end else begin
        tick();
        chk("rej_pending", ifc.cfg_pending, 0);
        chk("rej_busy", ifc.cfg_busy, 0);
        chk("rej_x_scale", x_scale, cur.xs);
        chk("rej_end_x", end_x, cur.ex);
      end
    end

    // vsync during DIV_X plus a cfg_wr while busy
    send(vecs[7]);
    repeat (4) tick();
    vs_i = 1'b1;
    tick();
    chk("middiv_sstart", scaler_start, 1);
    chk("middiv_applied", cfg_applied, 0);
    chk("middiv_x_scale", x_scale, cur.xs);
    vs_i = 1'b0;
    drive(vecs[1]);
    ifc.cfg_wr = 1'b1;
    tick();
    ifc.cfg_wr = 1'b0;
    chk("busy_wr_ack", ifc.cfg_ack, 0);
    chk("busy_wr_err", ifc.cfg_err, 0);
    wait_pend(7, 51, 0);
    vsync_pulse(1'b1);

    // cfg_wr coinciding with commit: commit wins
    send(vecs[0]);
    wait_pend(1, 51, 0);
    drive(vecs[9]);
    ifc.cfg_wr = 1'b1;
    vs_i = 1'b1;
    tick();
    ifc.cfg_wr = 1'b0;
    chk("collide_applied", cfg_applied, 1);
    chk("collide_ack", ifc.cfg_ack, 0);
    chk("collide_busy", ifc.cfg_busy, 0);
    chk("collide_pending", ifc.cfg_pending, 0);
    tick();
    vs_i = 1'b0;
    tick();

    // reject keeps pending; accept in PEND replaces it
    send(vecs[1]);
    wait_pend(1, 51, 0);
    send(vecs[5]);
    chk("rej_keeps_pending", ifc.cfg_pending, 1);
    send(vecs[9]);
    chk("reaccept_drops_pending", ifc.cfg_pending, 0);
    wait_pend(1, 51, 0);
    vsync_pulse(1'b1);

    // async reset during DIV_Y
    send(vecs[2]);
    repeat (30) tick();
    chk("in_div_y_busy", ifc.cfg_busy, 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_pend = 1'b0;
    cur = mk(0, 1280, 0, 720, 1279, 719, 1, 'h4000, 'h4000, 0);
    chk_defaults("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_defaults("post_rst");
    vsync_pulse(1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scaler_cfg_ctrl.md
Name: scaler_cfg_ctrl

Overview:
Frame-synchronous configuration controller for the crop + stream-scaler video path. Accepts a new crop window and output resolution from the CPU/register side, validates it, and computes the Q4.14 x/y scale factors with a shared sequential divider. It commits the new set atomically at the next vsync rising edge, then issues the one-cycle scaler start pulse. Sits in the clk_vpm domain, replacing the static crop/scale constants feeding image_cut and streamScaler.

Parameters:
X_W, 11, output/input X resolution width (res-minus-1 fields)
Y_W, 11, output/input Y resolution width
H_DISP, 1280, max legal end_x
V_DISP, 720, max legal end_y
SCALE_INT_BITS, 4, scale integer bits
SCALE_FRAC_BITS, 14, scale fraction bits; SB = 18 total

Ports:
clk  in  1  processing clock (clk_vpm)
rst  in  1  asynchronous active-high reset
cfg_wr  in  1  one-cycle request to load new config
cfg_start_x / cfg_end_x  in  X_W+1  crop window X, end exclusive
cfg_start_y / cfg_end_y  in  Y_W+1  crop window Y, end exclusive
cfg_out_xres  in  X_W  output width minus 1
cfg_out_yres  in  Y_W  output height minus 1
cfg_ack  out  1  pulse: request accepted
cfg_err  out  1  pulse: request rejected or scale saturated
cfg_busy  out  1  divider running
cfg_pending  out  1  computed set waiting for vsync
vs_i  in  1  vsync level, already synchronous to clk
start_x, end_x  out  X_W+1  active crop window
start_y, end_y  out  Y_W+1
input_x_res / input_y_res  out  X_W / Y_W  active crop size minus 1
output_x_res / output_y_res  out  X_W / Y_W  active output res minus 1
x_scale, y_scale  out  SB  active Q4.14 scale = (in_res+1)*2^14/(out_res+1)
scaler_start  out  1  one-cycle frame start to scaler/FIFO reset
cfg_applied  out  1  pulse: pending set committed this cycle

Behaviour:
- Reset: active set = full-frame passthrough. start 0/0, end H_DISP/V_DISP, input/output res H_DISP-1/V_DISP-1, scales 0x04000. All pulses, busy and pending are 0. FSM in IDLE.
- FSM: IDLE -> DIV_X -> DIV_Y -> PEND -> IDLE. The PEND -> IDLE transition happens on a vsync edge.
- cfg_wr is sampled in IDLE or PEND only; it is ignored in DIV_X/DIV_Y (no ack, no err).
- Validation happens in the cfg_wr cycle. Reject (cfg_err pulse next cycle, state unchanged, existing pending set kept) if any of:
  - end <= start
  - end - start > 2^X_W (resp. 2^Y_W)
  - end_x > H_DISP or end_y > V_DISP
- Accept: inputs are latched into the shadow set, cfg_ack pulses next cycle, and the FSM enters DIV_X. An accept in PEND discards the old pending set.
- Divider: restoring, one quotient bit per cycle, 25 cycles per axis. Numerator = (end-start) << 14; divisor = out_res+1.
  - If the quotient is >= 2^18, saturate to 0x3FFFF and pulse cfg_err at the end of that axis. The set is still committed.
- cfg_busy is high throughout DIV_X/DIV_Y. cfg_wr to cfg_pending high is 51 cycles.
- vsync edge: vs_i is registered once; rise = vs_i & ~vs_q.
  - scaler_start pulses the cycle after every rising edge, regardless of state.
  - If in PEND in that same cycle, the active set is replaced by the shadow set, cfg_applied pulses, and the FSM goes to IDLE. Outputs and scaler_start therefore change together.
- Vsync edge during DIV_*: scaler_start pulses and the old active set is kept. The commit waits for the next edge after PEND.
- cfg_wr in the same cycle as a commit in PEND: the commit wins and cfg_wr is ignored.
- Async reset mid-division: aborts immediately and restores reset values.
- input_*_res = end-start-1, truncated to the res width.

Optional Feature:
SCALER_CFG_ROUND_EN
- Defined: numerator gets (out_res+1)>>1 added before division, giving round-to-nearest scale.
- Undefined: truncating division.
- Saturation and timing are identical in both builds.

Test Plan:
- Reset, then a vs_i rising edge -> scaler_start one pulse one cycle after the edge; x_scale = y_scale = 0x04000; cfg_applied = 0.
- cfg_wr with window 0..640 x 0..360, out 1279/719 -> ack next cycle; pending after 51 cycles. Next vs edge -> x_scale = y_scale = 0x02000, input res 639/359, cfg_applied together with scaler_start.
- cfg_wr with window 0..2, out_xres 2 -> x_scale 0x02AAA (ROUND_EN off) or 0x02AAB (on).
- cfg_wr with window 0..100, out_xres 2 -> x_scale saturates to 0x3FFFF, cfg_err pulse, set still committed at vsync.
- cfg_wr with end_x = start_x, and separately end_x = 1281 -> cfg_err, no ack, active and pending unchanged.
- Vsync edge mid-DIV_X, then a second cfg_wr during busy -> old set kept, second request ignored, first set commits at the following edge.
- rst asserted during DIV_Y -> all outputs back to passthrough defaults.
